// File: rtl/input_cond_pkg.sv
// input_cond_pkg: state encodings and default constants shared by input-conditioning blocks
package input_cond_pkg;
   localparam logic [1:0] IDLE_LOW  = 2'b00;
   localparam logic [1:0] WAIT_HIGH = 2'b01;
   localparam logic [1:0] IDLE_HIGH = 2'b11;
   localparam logic [1:0] WAIT_LOW  = 2'b10;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 4;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: plain N-flop synchroniser for an asynchronous single-bit input
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] r;
   // shift the raw input through the chain with no logic between stages
   always_ff @(posedge clk or negedge rst)
      if (!rst) r <= '0;
      else r <= {r[STAGES-2:0], d};
   assign q = r[STAGES-1];
endmodule

// File: rtl/input_debounce_edge.sv
// input_debounce_edge: synchronise and debounce a raw input, emitting rise/fall pulses and a toggle level
module input_debounce_edge
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic din_raw,
   output logic d_clean,
   output logic rise,
   output logic fall,
   output logic toggle,
   output logic busy
);
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   logic s;
   logic [1:0] state;
   logic [CNT_W-1:0] cnt;
   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .d(din_raw),
      .q(s)
   );
   // qualify each candidate level for DB_CYCLES consecutive samples; any bounce drops back to idle
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE_LOW;
         cnt     <= '0;
         d_clean <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         toggle  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE_LOW:
               if (s) begin
                  state <= WAIT_HIGH;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end
            WAIT_HIGH:
               if (!s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE_HIGH;
                  cnt     <= '0;
                  d_clean <= 1'b1;
                  rise    <= 1'b1;
                  toggle  <= ~toggle;
                  busy    <= 1'b0;
               end else cnt <= cnt + 1'b1;
            IDLE_HIGH:
               if (!s) begin
                  state <= WAIT_LOW;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end
            WAIT_LOW:
               if (s) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE_LOW;
                  cnt     <= '0;
                  d_clean <= 1'b0;
                  fall    <= 1'b1;
                  busy    <= 1'b0;
               end else cnt <= cnt + 1'b1;
         endcase
      end
endmodule

// File: tb/tb_input_debounce_edge.sv
// tb_input_debounce_edge: vector table, hand sequences and random stimulus against a run-length model
module tb_input_debounce_edge;
   localparam int S  = 2;
   localparam int DB = 4;
   typedef struct packed {
      bit         din;
      logic [4:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic din_raw = 1'b0;
   logic d_clean, rise, fall, toggle, busy;
   logic [4:0] outs;
   int checks = 0;
   int errors = 0;
   bit pipe[$];
   int run;
   bit m_d, m_r, m_f, m_t;
   vec_t tbl[43];

   input_debounce_edge #(.SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
      .clk(clk),
      .rst(rst),
      .din_raw(din_raw),
      .d_clean(d_clean),
      .rise(rise),
      .fall(fall),
      .toggle(toggle),
      .busy(busy)
   );

   always #5 clk = ~clk;
   assign outs = {d_clean, rise, fall, toggle, busy};

   function automatic logic [4:0] model_out();
      return {m_d, m_r, m_f, m_t, run != 0};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (d_clean,rise,fall,toggle,busy)", name, act, exp);
      end
   endtask

   task automatic model_reset();
      pipe = {};
      repeat (S) pipe.push_back(1'b0);
      run = 0;
      m_d = 0;
      m_r = 0;
      m_f = 0;
      m_t = 0;
   endtask

   // the FSM sees the raw level sampled S edges earlier; d_clean follows after DB consecutive opposite samples
   task automatic model_edge(bit din);
      bit sv;
      sv = pipe.pop_front();
      pipe.push_back(din);
      m_r = 0;
      m_f = 0;
      if (sv == m_d) run = 0;
      else begin
         run++;
         if (run == DB) begin
            m_d = sv;
            m_r = sv;
            m_f = !sv;
            if (sv) m_t = !m_t;
            run = 0;
         end
      end
   endtask

   task automatic step(bit din, output logic [4:0] o);
      @(negedge clk) din_raw = din;
      @(posedge clk);
      model_edge(din);
      #1;
      o = outs;
      check("model", 32'(o), 32'(model_out()));
   endtask

   task automatic reset_pulse(int cycles, bit din_after);
      rst = 1'b0;
      model_reset();
      #1 check("reset_async", 32'(outs), 32'd0);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk) din_raw = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 check("reset_hold", 32'(outs), 32'd0);
      end
      @(posedge clk);
      #2;
      din_raw = din_after;
      rst = 1'b1;
   endtask

   initial begin
      logic [4:0] o;
      int rise_edge;
      bit v;
      int len;
      tbl = '{
         '{1, 5'b00000}, '{1, 5'b00000}, '{1, 5'b00001}, '{1, 5'b00001}, '{1, 5'b00001},
         '{1, 5'b11010}, '{1, 5'b10010}, '{0, 5'b10010}, '{0, 5'b10010}, '{0, 5'b10011},
         '{0, 5'b10011}, '{0, 5'b10011}, '{0, 5'b00110}, '{0, 5'b00010}, '{1, 5'b00010},
         '{1, 5'b00010}, '{1, 5'b00011}, '{0, 5'b00011}, '{0, 5'b00011}, '{0, 5'b00010},
         '{0, 5'b00010}, '{0, 5'b00010}, '{1, 5'b00010}, '{0, 5'b00010}, '{1, 5'b00011},
         '{1, 5'b00010}, '{0, 5'b00011}, '{1, 5'b00011}, '{1, 5'b00010}, '{1, 5'b00011},
         '{1, 5'b00011}, '{1, 5'b00011}, '{1, 5'b11000}, '{1, 5'b10000}, '{1, 5'b10000},
         '{1, 5'b10000}, '{0, 5'b10000}, '{0, 5'b10000}, '{0, 5'b10001}, '{0, 5'b10001},
         '{0, 5'b10001}, '{0, 5'b00100}, '{0, 5'b00000}
      };
      #3;
      reset_pulse(4, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, o);
         check("idle_after_reset", 32'(o), 32'd0);
      end
      for (int i = 0; i < 43; i++) begin
         step(tbl[i].din, o);
         check($sformatf("vec%0d", i), 32'(o), 32'(tbl[i].exp));
      end
      reset_pulse(2, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, o);
      check("mid_qual_busy", 32'(busy), 32'd1);
      reset_pulse(2, 1'b1);
      rise_edge = -1;
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, o);
         if (o[3] && rise_edge < 0) rise_edge = i;
      end
      check("rise_after_release", 32'(rise_edge), 32'(S + DB));
      check("d_clean_before_reset", 32'(d_clean), 32'd1);
      reset_pulse(1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, o);
         check("no_fall_after_reset", 32'(o), 32'd0);
      end
      for (int n = 0; n < 400; n++) begin
         v = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         if ($urandom_range(0, 39) == 0) reset_pulse($urandom_range(0, 2), v);
         for (int j = 0; j < len; j++) step(v, o);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
